// File: rtl/dp_pkg.sv
// Shared definitions for the 4-bit datapath sequencer: widths, op-codes, FSM states.
package dp_pkg;

    localparam int unsigned DW  = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned OPW = 4;

    typedef logic [OPW-1:0] op_t;

    localparam op_t OP_NOP  = 4'h0;
    localparam op_t OP_ADD  = 4'h1;
    localparam op_t OP_SUB  = 4'h2;
    localparam op_t OP_MUL  = 4'h3;
    localparam op_t OP_DIV  = 4'h4;
    localparam op_t OP_AND  = 4'h5;
    localparam op_t OP_OR   = 4'h6;
    localparam op_t OP_XNOR = 4'h7;
    localparam op_t OP_XOR  = 4'h8;
    localparam op_t OP_ROR  = 4'h9;
    localparam op_t OP_ROL  = 4'hA;
    localparam op_t OP_LDR  = 4'hB;
    localparam op_t OP_STR  = 4'hC;
    localparam op_t OP_LDI  = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EX   = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/dp_decode.sv
// Combinational op-code classifier for the sequencer.
module dp_decode
    import dp_pkg::*;
(
    input  op_t  op,
    output logic is_alu,
    output logic is_ldr,
    output logic is_str,
    output logic is_ldi,
    output logic illegal,
    output logic uses_ram
);

    always_comb begin
        is_alu   = (op <= OP_ROL);
        is_ldr   = (op == OP_LDR);
        is_str   = (op == OP_STR);
        is_ldi   = (op == OP_LDI);
        illegal  = !(is_alu || is_ldr || is_str || is_ldi);
        // RAM is read for every legal op except LDI, whose a2 is an immediate
        uses_ram = is_alu || is_ldr || is_str;
    end

endmodule

// File: rtl/dp_sequencer.sv
// Four-state (IDLE/RD/EX/WB) instruction sequencer owning all register-file,
// RAM and ALU control lines of the 4-bit datapath.
module dp_sequencer #(
    parameter int unsigned DW = dp_pkg::DW,
    parameter int unsigned AW = dp_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [11:0]   instr,
    output logic          instr_ready,
    output logic [AW-1:0] rf_addr,
    output logic          rf_we,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    output logic          ram_wr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_y,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          err
);
    import dp_pkg::*;

    localparam int unsigned IW = 12;

    state_t        state_q, state_d;
    logic [IW-1:0] instr_q, instr_d;
    logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
    logic          ready_q, ready_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d, ram_addr_q, ram_addr_d;
    logic          ram_rd_q, ram_rd_d, rf_we_q, rf_we_d, ram_wr_q, ram_wr_d;
    logic          done_q, done_d, err_q, err_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d, result_q, result_d;
    op_t           alu_op_q, alu_op_d;

    op_t           op_sel;
    logic          is_alu, is_ldr, is_str, is_ldi, illegal, uses_ram;
    logic          accept;
    logic [DW-1:0] wb_data;

    // In IDLE decode the offered word so RD strobes can be registered on the accepting edge
    assign accept = (state_q == S_IDLE) && instr_valid && ready_q;
    assign op_sel = (state_q == S_IDLE) ? op_t'(instr[11:8]) : op_t'(instr_q[11:8]);

    dp_decode u_decode (
        .op       (op_sel),
        .is_alu   (is_alu),
        .is_ldr   (is_ldr),
        .is_str   (is_str),
        .is_ldi   (is_ldi),
        .illegal  (illegal),
        .uses_ram (uses_ram)
    );

    // Write-back value; a zero divisor forces 0 regardless of what the ALU returns
    always_comb begin
        wb_data = alu_y;
        if (is_ldr || is_ldi) begin
            wb_data = opb_q;
        end else if ((op_t'(instr_q[11:8]) == OP_DIV) && (opb_q == '0)) begin
            wb_data = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        ready_d     = ready_q;
        rf_addr_d   = rf_addr_q;
        ram_addr_d  = ram_addr_q;
        ram_rd_d    = 1'b0;
        rf_we_d     = 1'b0;
        ram_wr_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        alu_op_d    = alu_op_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        result_d    = result_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    instr_d    = instr;
                    state_d    = S_RD;
                    ready_d    = 1'b0;
                    rf_addr_d  = AW'(instr[7:4]);
                    ram_addr_d = AW'(instr[3:0]);
                    ram_rd_d   = uses_ram;
                end
            end
            S_RD: begin
                state_d  = S_EX;
                alu_op_d = is_alu ? op_sel : OP_NOP;
            end
            S_EX: begin
                state_d = S_WB;
                opa_d   = rf_rdata;
                opb_d   = is_ldi ? DW'(instr_q[3:0]) : ram_rdata;
                rf_we_d = is_alu || is_ldr || is_ldi;
                ram_wr_d = is_str;
                if (is_str) begin
                    ram_wdata_d = rf_rdata;
                end
                done_d = 1'b1;
                err_d  = illegal || ((op_sel == OP_DIV) && (ram_rdata == '0));
            end
            S_WB: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                if (rf_we_q) begin
                    result_d = wb_data;
                end else if (ram_wr_q) begin
                    result_d = ram_wdata_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            ready_q     <= 1'b0;
            rf_addr_q   <= '0;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            rf_we_q     <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_wdata_q <= '0;
            alu_op_q    <= OP_NOP;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            ready_q     <= ready_d;
            rf_addr_q   <= rf_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_q    <= ram_rd_d;
            rf_we_q     <= rf_we_d;
            ram_wr_q    <= ram_wr_d;
            ram_wdata_q <= ram_wdata_d;
            alu_op_q    <= alu_op_d;
            done_q      <= done_d;
            err_q       <= err_d;
            result_q    <= result_d;
        end
    end

    assign instr_ready = ready_q;
    assign rf_addr     = rf_addr_q;
    assign rf_we       = rf_we_q;
    assign rf_wdata    = rf_we_q ? wb_data : '0;
    assign ram_addr    = ram_addr_q;
    assign ram_rd      = ram_rd_q;
    assign ram_wr      = ram_wr_q;
    assign ram_wdata   = ram_wdata_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = opa_q;
    assign alu_b       = opb_q;
    assign done        = done_q;
    assign result      = result_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: behavioural RF/RAM/ALU around the DUT, a table of
// instructions with hand-computed write-backs, and a scoreboard checked on done.
module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [11:0] instr;
    logic        instr_ready;
    logic [3:0]  rf_addr, rf_wdata, rf_rdata;
    logic        rf_we;
    logic [3:0]  ram_addr, ram_wdata, ram_rdata;
    logic        ram_rd, ram_wr;
    logic [3:0]  alu_op, alu_a, alu_b, alu_y;
    logic        done, err;
    logic [3:0]  result;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [11:0] ins;
        logic        gap;
        logic        we;
        logic        wr;
        logic [3:0]  addr;
        logic [3:0]  data;
        logic        err;
        logic [3:0]  res;
    } vec_t;

    typedef struct {
        logic       we;
        logic       wr;
        logic [3:0] addr;
        logic [3:0] data;
        logic       err;
        logic [3:0] res;
        int         acc;
    } exp_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    exp_t sb [$];

    logic [3:0] rf_mem  [16];
    logic [3:0] ram_mem [16];
    logic       res_pend = 1'b0;
    logic [3:0] res_exp  = 4'h0;
    logic [37:0] all_out;

    assign all_out = {instr_ready, rf_addr, rf_we, rf_wdata, ram_addr, ram_rd, ram_wr,
                      ram_wdata, alu_op, alu_a, alu_b, done, result, err};

    dp_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_addr     (rf_addr),
        .rf_we       (rf_we),
        .rf_wdata    (rf_wdata),
        .rf_rdata    (rf_rdata),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_wr      (ram_wr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_y       (alu_y),
        .done        (done),
        .result      (result),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories; reset loads rf[i]=i, ram[i]=2i
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_mem[i]  <= 4'(i);
                ram_mem[i] <= 4'(2 * i);
            end
            rf_rdata  <= 4'h0;
            ram_rdata <= 4'h0;
        end else begin
            rf_rdata <= rf_mem[rf_addr];
            if (ram_rd) ram_rdata <= ram_mem[ram_addr];
            if (rf_we) rf_mem[rf_addr] <= rf_wdata;
            if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
        end
    end

    // ALU; divide by zero returns F so the sequencer's forced 0 is visible
    logic [7:0] prod;
    always_comb begin
        prod  = {4'h0, alu_a} * {4'h0, alu_b};
        alu_y = 4'h0;
        case (alu_op)
            4'h0: alu_y = alu_a;
            4'h1: alu_y = alu_a + alu_b;
            4'h2: alu_y = alu_a - alu_b;
            4'h3: alu_y = prod[3:0];
            4'h4: alu_y = (alu_b == 4'h0) ? 4'hF : alu_a / alu_b;
            4'h5: alu_y = alu_a & alu_b;
            4'h6: alu_y = alu_a | alu_b;
            4'h7: alu_y = ~(alu_a ^ alu_b);
            4'h8: alu_y = alu_a ^ alu_b;
            4'h9: alu_y = {alu_a[0], alu_a[3:1]};
            4'hA: alu_y = {alu_a[2:0], alu_a[3]};
            default: alu_y = 4'h0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer and cycle-level strobe checks
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            res_pend = 1'b0;
        end else begin
            if (res_pend) begin
                chk("result", 64'(result), 64'(res_exp));
                res_pend = 1'b0;
            end
            if (!done) chk("strobes_outside_wb", 64'({rf_we, ram_wr, err}), 64'(0));
            if (sb.size() != 0) chk("ready_while_busy", 64'(instr_ready), 64'(0));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("latency", 64'(cyc - e.acc), 64'(3));
                    chk("rf_we", 64'(rf_we), 64'(e.we));
                    chk("ram_wr", 64'(ram_wr), 64'(e.wr));
                    chk("err", 64'(err), 64'(e.err));
                    if (e.we) chk("rf_addr/data", 64'({rf_addr, rf_wdata}), 64'({e.addr, e.data}));
                    if (e.wr) chk("ram_addr/data", 64'({ram_addr, ram_wdata}), 64'({e.addr, e.data}));
                    res_pend = 1'b1;
                    res_exp  = e.res;
                end
            end
        end
    end

    task automatic send(input logic [11:0] w, input logic push, input exp_t e, input logic b2b);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr       = w;
        while (!instr_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 64'(instr_ready), 64'(1));
            return;
        end
        if (b2b) chk("b2b_ready_gap", 64'(n), 64'(3));
        @(posedge clk);
        #1;
        if (push) begin
            e.acc = cyc - 1;
            sb.push_back(e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n;
        //          ins      gap   we    wr    addr   data   err   res
        vecs[0]  = '{12'hD35, 1'b1, 1'b1, 1'b0, 4'h3, 4'h5, 1'b0, 4'h5};  // LDI r3,#5
        vecs[1]  = '{12'h132, 1'b1, 1'b1, 1'b0, 4'h3, 4'h9, 1'b0, 4'h9};  // ADD r3,ram[2]=4
        vecs[2]  = '{12'hC37, 1'b1, 1'b0, 1'b1, 4'h7, 4'h9, 1'b0, 4'h9};  // STR r3->ram[7]
        vecs[3]  = '{12'hE12, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h9};  // illegal
        vecs[4]  = '{12'h410, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 4'h0};  // DIV by 0
        vecs[5]  = '{12'hB47, 1'b1, 1'b1, 1'b0, 4'h4, 4'h9, 1'b0, 4'h9};  // LDR r4,ram[7]
        vecs[6]  = '{12'h245, 1'b0, 1'b1, 1'b0, 4'h4, 4'hF, 1'b0, 4'hF};  // SUB 9-10
        vecs[7]  = '{12'h323, 1'b0, 1'b1, 1'b0, 4'h2, 4'hC, 1'b0, 4'hC};  // MUL 2*6
        vecs[8]  = '{12'h345, 1'b0, 1'b1, 1'b0, 4'h4, 4'h6, 1'b0, 4'h6};  // MUL 15*10 trunc
        vecs[9]  = '{12'h421, 1'b1, 1'b1, 1'b0, 4'h2, 4'h6, 1'b0, 4'h6};  // DIV 12/2
        vecs[10] = '{12'h525, 1'b1, 1'b1, 1'b0, 4'h2, 4'h2, 1'b0, 4'h2};  // AND
        vecs[11] = '{12'h623, 1'b1, 1'b1, 1'b0, 4'h2, 4'h6, 1'b0, 4'h6};  // OR
        vecs[12] = '{12'h725, 1'b1, 1'b1, 1'b0, 4'h2, 4'h3, 1'b0, 4'h3};  // XNOR
        vecs[13] = '{12'h826, 1'b1, 1'b1, 1'b0, 4'h2, 4'hF, 1'b0, 4'hF};  // XOR
        vecs[14] = '{12'h930, 1'b1, 1'b1, 1'b0, 4'h3, 4'hC, 1'b0, 4'hC};  // ROR 1001
        vecs[15] = '{12'hA30, 1'b1, 1'b1, 1'b0, 4'h3, 4'h9, 1'b0, 4'h9};  // ROL 1100
        vecs[16] = '{12'h051, 1'b1, 1'b1, 1'b0, 4'h5, 4'h5, 1'b0, 4'h5};  // NOP passes a
        vecs[17] = '{12'hF00, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h5};  // illegal
        vecs[18] = '{12'h464, 1'b1, 1'b1, 1'b0, 4'h6, 4'h0, 1'b0, 4'h0};  // DIV 6/8
        vecs[19] = '{12'hD0F, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0, 4'hF};  // LDI r0,#F
        vecs[20] = '{12'h101, 1'b1, 1'b1, 1'b0, 4'h0, 4'h1, 1'b0, 4'h1};  // ADD sees LDI

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 12'h000;
        e           = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'(all_out), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", 64'(instr_ready), 64'(1));

        // ADD in flight, reset asserted while in RD
        send(12'h132, 1'b0, e, 1'b0);
        instr_valid = 1'b0;
        chk("rd_strobes", 64'({rf_addr, ram_addr, ram_rd, instr_ready}), 64'({4'h3, 4'h2, 1'b1, 1'b0}));
        #1 rst = 1'b1;
        #1 chk("async_reset_outputs", 64'(all_out), 64'(0));
        repeat (2) begin
            @(negedge clk);
            chk("reset_strobes", 64'({rf_we, ram_wr, done}), 64'(0));
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_one_cycle_after_release", 64'(instr_ready), 64'(1));
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_done", 64'({done, rf_we, ram_wr, instr_ready}), 64'(1));
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            e.we   = vecs[i].we;
            e.wr   = vecs[i].wr;
            e.addr = vecs[i].addr;
            e.data = vecs[i].data;
            e.err  = vecs[i].err;
            e.res  = vecs[i].res;
            send(vecs[i].ins, 1'b1, e, (i > 0) && !vecs[i-1].gap);
            if (vecs[i].gap) begin
                // Garbage on instr while not offered must not affect the latched word
                instr_valid = 1'b0;
                instr       = 12'hE5A;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        instr_valid = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
